// File: rtl/bcd_keypad_entry_if.sv
// -----------------------------------------------------------------------------
// bcd_keypad_entry_if
//   Bundles the keypad handshake, the operand/result bus to and from the
//   combinational BCD subtractor, and the display/status outputs of the
//   keypad entry controller.
//
//   key_valid / key_code / key_ready : key strobe handshake
//   A / B                            : BCD operands driven to the subtractor
//   diff_bcd / borrow                : subtractor difference magnitude and borrow
//   result_bcd / result_neg / result_valid : registered result
//   disp_bcd / disp_neg              : display value and sign
//   error                            : sticky entry error
//
//   slave  : the controller side
//   master : the environment side (keypad source, subtractor, display)
// -----------------------------------------------------------------------------
interface bcd_keypad_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] diff_bcd;
    logic       borrow;
    logic [7:0] result_bcd;
    logic       result_neg;
    logic       result_valid;
    logic [7:0] disp_bcd;
    logic       disp_neg;
    logic       error;

    modport slave (
        input  key_valid, key_code, diff_bcd, borrow,
        output key_ready, A, B, result_bcd, result_neg, result_valid,
               disp_bcd, disp_neg, error
    );

    modport master (
        output key_valid, key_code, diff_bcd, borrow,
        input  key_ready, A, B, result_bcd, result_neg, result_valid,
               disp_bcd, disp_neg, error
    );
endinterface

// File: rtl/bcd_keypad_entry.sv
// -----------------------------------------------------------------------------
// bcd_keypad_entry
//   Keypad operand-entry and result-capture controller for a two-digit BCD
//   calculator. Digit, minus, equals and clear strobes build operands A and B,
//   which feed an external combinational BCD subtractor; its difference and
//   borrow are captured one cycle after equals and shown on the display.
//
//   Parameter AUTO_CLEAR : 1 = a digit in SHOW starts a new A entry,
//                          0 = digits are ignored in SHOW.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : bcd_keypad_entry_if.slave (handshake, operands, result, display)
// -----------------------------------------------------------------------------
module bcd_keypad_entry #(
    parameter bit AUTO_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bcd_keypad_entry_if.slave bus
);
    typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_e;

    localparam logic [3:0] KEY_MINUS  = 4'hA;
    localparam logic [3:0] KEY_EQUALS = 4'hB;
    localparam logic [3:0] KEY_CLEAR  = 4'hC;

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [1:0] cnt_a_q, cnt_a_d;
    logic [1:0] cnt_b_q, cnt_b_d;
    logic [7:0] result_q, result_d;
    logic       neg_q, neg_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;

    logic       accept;
    logic       is_digit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ENTER_A;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            cnt_a_q  <= 2'd0;
            cnt_b_q  <= 2'd0;
            result_q <= 8'h00;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal defaults to its held value first, so
        // no branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        result_d = result_q;
        neg_d    = neg_q;
        valid_d  = valid_q;
        error_d  = error_q;

        // CALC never accepts a key, so strobes there are simply dropped.
        accept   = bus.key_valid && (state_q != CALC);
        is_digit = (bus.key_code <= 4'd9);

        if (state_q == CALC) begin
            // Operands have been stable since equals; capture the subtractor.
            result_d = bus.diff_bcd;
            neg_d    = bus.borrow;
            valid_d  = 1'b1;
            state_d  = SHOW;
        end else if (accept) begin
            if (bus.key_code == KEY_CLEAR) begin
                state_d  = ENTER_A;
                a_d      = 8'h00;
                b_d      = 8'h00;
                cnt_a_d  = 2'd0;
                cnt_b_d  = 2'd0;
                result_d = 8'h00;
                neg_d    = 1'b0;
                valid_d  = 1'b0;
                error_d  = 1'b0;
            end else if (!error_q) begin
                case (state_q)
                    ENTER_A: begin
                        if (is_digit && cnt_a_q < 2'd2) begin
                            a_d     = {a_q[3:0], bus.key_code};
                            cnt_a_d = cnt_a_q + 2'd1;
                        end else if (bus.key_code == KEY_MINUS) begin
                            b_d     = 8'h00;
                            cnt_b_d = 2'd0;
                            state_d = ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit && cnt_b_q < 2'd2) begin
                            b_d     = {b_q[3:0], bus.key_code};
                            cnt_b_d = cnt_b_q + 2'd1;
                        end else if (bus.key_code == KEY_EQUALS) begin
                            if (cnt_b_q == 2'd0) error_d = 1'b1;
                            else                 state_d = CALC;
                        end
                    end
                    SHOW: begin
                        if (is_digit && AUTO_CLEAR) begin
                            a_d     = {4'h0, bus.key_code};
                            cnt_a_d = 2'd1;
                            b_d     = 8'h00;
                            cnt_b_d = 2'd0;
                            valid_d = 1'b0;
                            state_d = ENTER_A;
                        end else if (bus.key_code == KEY_MINUS) begin
                            // A negative result has no BCD encoding as A.
                            if (neg_q) begin
                                error_d = 1'b1;
                            end else begin
                                a_d     = result_q;
                                cnt_a_d = 2'd2;
                                b_d     = 8'h00;
                                cnt_b_d = 2'd0;
                                valid_d = 1'b0;
                                state_d = ENTER_B;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (state_q)
            ENTER_A: bus.disp_bcd = a_q;
            SHOW:    bus.disp_bcd = result_q;
            default: bus.disp_bcd = b_q;
        endcase
    end

    assign bus.key_ready    = (state_q != CALC);
    assign bus.disp_neg     = neg_q && (state_q == SHOW);
    assign bus.A            = a_q;
    assign bus.B            = b_q;
    assign bus.result_bcd   = result_q;
    assign bus.result_neg   = neg_q;
    assign bus.result_valid = valid_q;
    assign bus.error        = error_q;

endmodule

// File: tb/tb_bcd_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_bcd_keypad_entry
//   Drives two controllers (AUTO_CLEAR=1 and AUTO_CLEAR=0) with the same key
//   stream and compares every output each cycle against a decimal-arithmetic
//   reference model. A behavioural BCD subtractor closes the loop.
// -----------------------------------------------------------------------------
module tb_bcd_keypad_entry;
    logic clk;
    logic rst;

    bcd_keypad_entry_if kif0 ();
    bcd_keypad_entry_if kif1 ();

    bcd_keypad_entry #(.AUTO_CLEAR(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(kif0.slave));
    bcd_keypad_entry #(.AUTO_CLEAR(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(kif1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural subtractor ----------------
    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] sub_mag(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = from_bcd(a) - from_bcd(b);
        return to_bcd(d < 0 ? -d : d);
    endfunction

    assign kif0.diff_bcd = sub_mag(kif0.A, kif0.B);
    assign kif0.borrow   = (from_bcd(kif0.A) < from_bcd(kif0.B));
    assign kif1.diff_bcd = sub_mag(kif1.A, kif1.B);
    assign kif1.borrow   = (from_bcd(kif1.A) < from_bcd(kif1.B));

    // ---------------- reference model ----------------
    typedef enum {M_A, M_B, M_CALC, M_SHOW} mode_t;
    typedef struct {
        mode_t mode;
        int    a_val, a_n, b_val, b_n, res;
        bit    neg, valid, err;
    } model_t;

    model_t mdl[2];

    function automatic model_t model_reset();
        model_t m;
        m.mode = M_A; m.a_val = 0; m.a_n = 0; m.b_val = 0; m.b_n = 0;
        m.res = 0; m.neg = 1'b0; m.valid = 1'b0; m.err = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input bit v, input int code,
                                          input bit ac);
        model_t n;
        n = m;
        if (m.mode == M_CALC) begin
            n.neg   = (m.a_val < m.b_val);
            n.res   = n.neg ? m.b_val - m.a_val : m.a_val - m.b_val;
            n.valid = 1'b1;
            n.mode  = M_SHOW;
        end else if (v) begin
            if (code == 12) begin
                n = model_reset();
            end else if (!m.err) begin
                if (code <= 9) begin
                    if (m.mode == M_A && m.a_n < 2) begin
                        n.a_val = (m.a_val % 10) * 10 + code; n.a_n = m.a_n + 1;
                    end else if (m.mode == M_B && m.b_n < 2) begin
                        n.b_val = (m.b_val % 10) * 10 + code; n.b_n = m.b_n + 1;
                    end else if (m.mode == M_SHOW && ac) begin
                        n.a_val = code; n.a_n = 1; n.b_val = 0; n.b_n = 0;
                        n.valid = 1'b0; n.mode = M_A;
                    end
                end else if (code == 10) begin
                    if (m.mode == M_A) begin
                        n.b_val = 0; n.b_n = 0; n.mode = M_B;
                    end else if (m.mode == M_SHOW) begin
                        if (m.neg) n.err = 1'b1;
                        else begin
                            n.a_val = m.res; n.a_n = 2; n.b_val = 0; n.b_n = 0;
                            n.valid = 1'b0; n.mode = M_B;
                        end
                    end
                end else if (code == 11 && m.mode == M_B) begin
                    if (m.b_n == 0) n.err = 1'b1;
                    else            n.mode = M_CALC;
                end
            end
        end
        return n;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_dut(input string p, input model_t m, input logic ready,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] rb, input logic rn, input logic rv,
                             input logic [7:0] db, input logic dn, input logic er);
        logic [7:0] exp_disp;
        case (m.mode)
            M_A:     exp_disp = to_bcd(m.a_val);
            M_SHOW:  exp_disp = to_bcd(m.res);
            default: exp_disp = to_bcd(m.b_val);
        endcase
        check({p, ".key_ready"},    32'(ready), 32'(m.mode != M_CALC));
        check({p, ".A"},            32'(a),     32'(to_bcd(m.a_val)));
        check({p, ".B"},            32'(b),     32'(to_bcd(m.b_val)));
        check({p, ".result_bcd"},   32'(rb),    32'(to_bcd(m.res)));
        check({p, ".result_neg"},   32'(rn),    32'(m.neg));
        check({p, ".result_valid"}, 32'(rv),    32'(m.valid));
        check({p, ".disp_bcd"},     32'(db),    32'(exp_disp));
        check({p, ".disp_neg"},     32'(dn),    32'(m.neg && m.mode == M_SHOW));
        check({p, ".error"},        32'(er),    32'(m.err));
    endtask

    task automatic check_all();
        check_dut("dut0", mdl[0], kif0.key_ready, kif0.A, kif0.B, kif0.result_bcd,
                  kif0.result_neg, kif0.result_valid, kif0.disp_bcd, kif0.disp_neg, kif0.error);
        check_dut("dut1", mdl[1], kif1.key_ready, kif1.A, kif1.B, kif1.result_bcd,
                  kif1.result_neg, kif1.result_valid, kif1.disp_bcd, kif1.disp_neg, kif1.error);
    endtask

    // One clock cycle with an optional strobe; entered and left 1 ns after an edge.
    task automatic cycle(input bit v, input int code);
        kif0.key_valid = v; kif0.key_code = 4'(code);
        kif1.key_valid = v; kif1.key_code = 4'(code);
        @(posedge clk);
        mdl[0] = model_step(mdl[0], v, code, 1'b1);
        mdl[1] = model_step(mdl[1], v, code, 1'b0);
        #1;
        kif0.key_valid = 1'b0; kif1.key_valid = 1'b0;
        check_all();
    endtask

    task automatic keys(input int seq[$]);
        foreach (seq[i]) cycle(1'b1, seq[i]);
    endtask

    // Asynchronous reset: checked immediately, then released on a falling edge.
    task automatic do_reset();
        kif0.key_valid = 1'b0; kif1.key_valid = 1'b0;
        rst = 1'b1;
        #1;
        mdl[0] = model_reset();
        mdl[1] = model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        kif0.key_valid = 1'b0; kif0.key_code = 4'h0;
        kif1.key_valid = 1'b0; kif1.key_code = 4'h0;
        do_reset();

        // 42 - 17 = 25
        keys('{4, 2, 10, 1, 7, 11});
        check("plan1.A", 32'(kif0.A), 32'h42);
        check("plan1.B", 32'(kif0.B), 32'h17);
        check("plan1.valid_before", 32'(kif0.result_valid), 32'h0);
        cycle(1'b0, 0);
        check("plan1.result", 32'(kif0.result_bcd), 32'h25);
        check("plan1.valid", 32'(kif0.result_valid), 32'h1);

        // 15 - 40 = -25, minus on a negative result raises error
        keys('{12, 1, 5, 10, 4, 0, 11});
        cycle(1'b0, 0);
        check("plan2.result", 32'(kif0.result_bcd), 32'h25);
        check("plan2.disp_neg", 32'(kif0.disp_neg), 32'h1);
        keys('{10});
        check("plan2.error", 32'(kif0.error), 32'h1);
        keys('{12});
        check("plan2.cleared", 32'(kif0.error), 32'h0);

        // third digit ignored; equals with empty B is an error; digits locked out
        keys('{9, 8, 7});
        check("plan3.A", 32'(kif0.A), 32'h98);
        keys('{10, 11, 3});
        check("plan3.error", 32'(kif0.error), 32'h1);
        check("plan3.B", 32'(kif0.B), 32'h00);

        // chain 50-20=30, then 30-05=25; strobe in CALC dropped
        keys('{12, 5, 0, 10, 2, 0, 11});
        check("plan4.ready_calc", 32'(kif0.key_ready), 32'h0);
        cycle(1'b1, 7);
        keys('{10, 0, 5, 11});
        check("plan4.A", 32'(kif0.A), 32'h30);
        cycle(1'b1, 4);
        check("plan4.result", 32'(kif0.result_bcd), 32'h25);

        // auto-clear on vs off
        keys('{3});
        check("ac1.A", 32'(kif0.A), 32'h03);
        check("ac1.valid", 32'(kif0.result_valid), 32'h0);
        check("ac0.valid", 32'(kif1.result_valid), 32'h1);
        check("ac0.disp", 32'(kif1.disp_bcd), 32'h25);

        // reset while CALC is pending
        keys('{12, 1, 10, 1, 11});
        do_reset();
        check("rst.valid", 32'(kif0.result_valid), 32'h0);
        check("rst.ready", 32'(kif0.key_ready), 32'h1);

        // randomized key stream
        for (int i = 0; i < 1500; i++) begin
            int r;
            int code;
            r = int'($urandom_range(0, 99));
            if      (r < 60) code = int'($urandom_range(0, 9));
            else if (r < 75) code = 10;
            else if (r < 88) code = 11;
            else if (r < 95) code = 12;
            else             code = int'($urandom_range(13, 15));
            if ($urandom_range(0, 249) == 0) do_reset();
            else cycle($urandom_range(0, 3) != 0, code);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
